conv_rd_sched: RTL and testbench

CONV_RD_SCHED -- requirements
Module: conv_rd_sched

---
 rtl/conv_rd_sched.sv | 159 +++++++++++++++
 tb/tb_conv_rd_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_rd_sched.sv
// Frame scheduler for a KxK convolution: loads a raster image into an external RAM,
// then replays every window's taps as one RAM read per cycle with a registered tap stream.
module conv_rd_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr_rd,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  pix_valid,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic [3:0]            pix_tap,
  output logic                  pix_last,
  output logic                  frame_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] WR_LAST  = ADDR_WIDTH'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0] C_LAST   = ADDR_WIDTH'(IMG_W - K);
  localparam logic [ADDR_WIDTH-1:0] R_LAST   = ADDR_WIDTH'(IMG_H - K);
  localparam logic [3:0]            TAP_LAST = 4'(K * K - 1);
  localparam logic [3:0]            KC_LAST  = 4'(K - 1);

  typedef enum logic [2:0] {IDLE, LOAD, READ, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wcnt, r, c;
  logic [3:0]              kr, kc, tap;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    wr_last, last_tap, frame_end;
  logic                    vld_p1, last_p1, flast_p1;
  logic [3:0]              tap_p1;

  assign wr_last   = (wcnt == WR_LAST);
  assign last_tap  = (tap == TAP_LAST);
  assign frame_end = last_tap && (c == C_LAST) && (r == R_LAST);
  assign rd_addr   = ADDR_WIDTH'((int'(r) + int'(kr)) * IMG_W + int'(c) + int'(kc));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (in_valid && wr_last) state_nxt = READ;
      READ:    if (frame_end) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    ram_en      = 1'b0;
    ram_wr      = 1'b0;
    ram_addr_wr = '0;
    ram_addr_rd = '0;
    ram_din     = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          ram_en      = 1'b1;
          ram_wr      = 1'b1;
          ram_addr_wr = wcnt;
          ram_din     = in_data;
        end
      end
      READ: begin
        busy        = 1'b1;
        ram_en      = 1'b1;
        ram_addr_rd = rd_addr;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Counters: write index during LOAD, window/tap scan during READ (all wrap to 0 at frame end)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt <= '0;
      r    <= '0;
      c    <= '0;
      kr   <= '0;
      kc   <= '0;
      tap  <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) wcnt <= wr_last ? '0 : wcnt + ADDR_WIDTH'(1);
        READ: begin
          if (last_tap) begin
            tap <= '0;
            kr  <= '0;
            kc  <= '0;
            if (c == C_LAST) begin
              c <= '0;
              r <= (r == R_LAST) ? '0 : r + ADDR_WIDTH'(1);
            end else begin
              c <= c + ADDR_WIDTH'(1);
            end
          end else begin
            tap <= tap + 4'd1;
            if (kc == KC_LAST) begin
              kc <= '0;
              kr <= kr + 4'd1;
            end else begin
              kc <= kc + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: tap tags follow the read issue by one cycle to line up with ram_dout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      tap_p1   <= '0;
      last_p1  <= 1'b0;
      flast_p1 <= 1'b0;
    end else begin
      vld_p1   <= (state == READ);
      tap_p1   <= (state == READ) ? tap : '0;
      last_p1  <= (state == READ) && last_tap;
      flast_p1 <= (state == READ) && frame_end;
    end
  end

  assign pix_valid  = vld_p1;
  assign pix_data   = vld_p1 ? ram_dout : '0;
  assign pix_tap    = tap_p1;
  assign pix_last   = last_p1;
  assign frame_last = flast_p1;

endmodule

// File: tb/tb_conv_rd_sched.sv
// Directed bench for conv_rd_sched: RAM model, bus monitor, table-driven window checks
// and hand-written sequences for gaps, start pokes, mid-read reset and back-to-back frames.
module tb_conv_rd_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ram_en;
  logic       ram_wr;
  logic [5:0] ram_addr_wr;
  logic [5:0] ram_addr_rd;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [3:0] pix_tap;
  logic       pix_last;
  logic       frame_last;
  logic       busy;
  logic       done;

  conv_rd_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr_wr(ram_addr_wr),
    .ram_addr_rd(ram_addr_rd), .ram_din(ram_din), .ram_dout(ram_dout),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_tap(pix_tap), .pix_last(pix_last),
    .frame_last(frame_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) mem[ram_addr_wr] <= ram_din;
      else        ram_dout <= mem[ram_addr_rd];
    end
  end

  typedef struct {int data; int tap; int last; int flast;} pix_t;
  int   wa[$], wd[$], wc[$], ra[$], rc[$], dc[$], db[$];
  pix_t pq[$];
  int   cyc = 0, bus_bad = 0, pv_bad = 0;
  logic prev_rd = 1'b0, prev_rstn = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ram_en && ram_wr) begin
      wa.push_back(int'(ram_addr_wr));
      wd.push_back(int'(ram_din));
      wc.push_back(cyc);
    end
    if (ram_en && !ram_wr) begin
      ra.push_back(int'(ram_addr_rd));
      rc.push_back(cyc);
    end
    if (pix_valid)
      pq.push_back('{int'(pix_data), int'(pix_tap), int'(pix_last), int'(frame_last)});
    if (done) begin
      dc.push_back(cyc);
      db.push_back(int'(busy));
    end
    if (!ram_en && (ram_wr || ram_addr_wr != 0 || ram_addr_rd != 0 || ram_din != 0))
      bus_bad <= bus_bad + 1;
    if (ram_en && ram_wr && !in_valid) bus_bad <= bus_bad + 1;
    if (pix_valid !== (prev_rd && prev_rstn)) pv_bad <= pv_bad + 1;
    prev_rd   <= ram_en && !ram_wr;
    prev_rstn <= rst_n;
  end

  typedef struct {int idx; int addr; int tap; int last; int flast;} vec_t;
  vec_t tbl[18];
  int   vecs = 0, errs = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    longint bits;
    bits = longint'({in_ready, ram_en, ram_wr, ram_addr_wr, ram_addr_rd, ram_din, pix_valid,
                     pix_tap, pix_last, frame_last, busy, done, pix_data});
    chk(nm, bits, 0);
  endtask

  task automatic start_load(input int base, input bit gaps, input bit poke);
    int fed = 0;
    int b = 0;
    bit ph = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (fed < 64 && b < 1000) begin
      in_valid = gaps ? !ph : 1'b1;
      in_data  = 8'((base + fed) & 255);
      start    = poke && (fed == 10);
      tick();
      if (in_valid) fed++;
      ph = !ph;
      b++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    start    = 1'b0;
    if (poke) begin
      repeat (3) tick();
      start = 1'b1;
      repeat (2) tick();
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int d0);
    int b = 0;
    while (dc.size() == d0 && b < 2000) begin
      tick();
      b++;
    end
    tick();
  endtask

  task automatic check_frame(input int base, input int w0, input int r0, input int p0,
                             input int d0);
    int exp_a[$];
    int n;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            exp_a.push_back((r + kr) * 8 + c + kc);
    chk("wr_count", wa.size() - w0, 64);
    n = (wa.size() - w0 > 64) ? 64 : wa.size() - w0;
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", wa[w0+i], i);
      chk("wr_data", wd[w0+i], (base + i) & 255);
    end
    chk("rd_count", ra.size() - r0, 324);
    chk("pix_count", pq.size() - p0, 324);
    n = (ra.size() - r0 > 324) ? 324 : ra.size() - r0;
    for (int i = 0; i < n; i++) chk("rd_addr", ra[r0+i], exp_a[i]);
    n = (pq.size() - p0 > 324) ? 324 : pq.size() - p0;
    for (int i = 0; i < n; i++) begin
      chk("pix_data", pq[p0+i].data, (base + exp_a[i]) & 255);
      chk("pix_tap", pq[p0+i].tap, i % 9);
      chk("pix_last", pq[p0+i].last, (i % 9 == 8) ? 1 : 0);
      chk("frame_last", pq[p0+i].flast, (i == 323) ? 1 : 0);
    end
    foreach (tbl[t]) begin
      if (ra.size() > r0 + tbl[t].idx && pq.size() > p0 + tbl[t].idx) begin
        chk("tbl_rd_addr", ra[r0+tbl[t].idx], tbl[t].addr);
        chk("tbl_pix_data", pq[p0+tbl[t].idx].data, (base + tbl[t].addr) & 255);
        chk("tbl_pix_tap", pq[p0+tbl[t].idx].tap, tbl[t].tap);
        chk("tbl_pix_last", pq[p0+tbl[t].idx].last, tbl[t].last);
        chk("tbl_frame_last", pq[p0+tbl[t].idx].flast, tbl[t].flast);
      end else begin
        chk("tbl_present", 0, 1);
      end
    end
    chk("done_count", dc.size() - d0, 1);
    if (dc.size() > d0 && ra.size() > r0 && wa.size() > w0) begin
      chk("done_from_first_rd", dc[d0] - rc[r0] + 1, 326);
      chk("done_after_last_rd", dc[d0] - rc[ra.size()-1], 2);
      chk("busy_at_done", db[d0], 0);
      chk("load_to_read", rc[r0] - wc[wa.size()-1], 1);
    end
  endtask

  initial begin
    int fa[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int la[9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
    int w0, r0, p0, d0, psnap, b;
    for (int i = 0; i < 9; i++) begin
      tbl[i]   = '{i, fa[i], i, (i == 8) ? 1 : 0, 0};
      tbl[9+i] = '{315 + i, la[i], i, (i == 8) ? 1 : 0, (i == 8) ? 1 : 0};
    end

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    tick();

    // Frame A: continuous load, pixel value equals address
    w0 = wa.size(); r0 = ra.size(); p0 = pq.size(); d0 = dc.size();
    start_load(0, 1'b0, 1'b0);
    wait_done(d0);
    check_frame(0, w0, r0, p0, d0);

    // Frame B: toggled in_valid and start pokes during LOAD and READ
    w0 = wa.size(); r0 = ra.size(); p0 = pq.size(); d0 = dc.size();
    start_load(7, 1'b1, 1'b1);
    wait_done(d0);
    check_frame(7, w0, r0, p0, d0);

    // Frame C: back-to-back with a different data set
    w0 = wa.size(); r0 = ra.size(); p0 = pq.size(); d0 = dc.size();
    start_load(100, 1'b0, 1'b0);
    wait_done(d0);
    check_frame(100, w0, r0, p0, d0);

    // Reset at read 100, then a fresh frame
    r0 = ra.size();
    start_load(200, 1'b0, 1'b0);
    b = 0;
    while (ra.size() - r0 < 100 && b < 1000) begin
      tick();
      b++;
    end
    chk("reads_before_reset", ra.size() - r0, 100);
    rst_n = 1'b0;
    tick();
    psnap = pq.size();
    @(negedge clk);
    chk_zero("rst_mid_read");
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_quiet", longint'({ram_en, in_ready, busy, pix_valid, done}), 0);
    end
    tick();
    chk("no_pix_after_rst", pq.size() - psnap, 0);

    w0 = wa.size(); r0 = ra.size(); p0 = pq.size(); d0 = dc.size();
    start_load(33, 1'b0, 1'b0);
    wait_done(d0);
    check_frame(33, w0, r0, p0, d0);

    repeat (3) tick();
    chk("bus_invariants", bus_bad, 0);
    chk("pix_valid_timing", pv_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
